tile_move_controller: RTL and testbench

Parametrised tile-grid movement and collision controller for the overworld and gym maps. It accepts one-step move requests in the team's standard 2-bit direction code and checks each target against the grid edges and a writable blocked-tile bitmap. Allowed steps are animated pixel-by-pixel on frame ticks. It feeds sprite position and facing to the drawing logic and bump/done events to the game FSM.

---
 rtl/tile_move_controller.sv | 184 ++++++++++++++++++
 tb/tb_tile_move_controller.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/tile_move_controller.sv
// rtl/tile_move_controller.sv - tile-grid movement and collision controller
// Accepts one-step moves, checks edges and a blocked-tile bitmap, animates allowed steps on frame ticks.
module tile_move_controller #(
    parameter int COLS      = 20,
    parameter int ROWS      = 15,
    parameter int TILE      = 32,
    parameter int STEP_PX   = 4,
    parameter int ORIGIN_X  = 0,
    parameter int ORIGIN_Y  = 0,
    parameter int START_COL = 5,
    parameter int START_ROW = 5,
    parameter int POS_W     = 10,
    localparam int CW = $clog2(COLS),
    localparam int RW = $clog2(ROWS)
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             frame_tick,
    input  logic             move_valid,
    input  logic [1:0]       move_dir,
    output logic             move_ready,
    input  logic             warp_valid,
    input  logic [CW-1:0]    warp_col,
    input  logic [RW-1:0]    warp_row,
    input  logic             wall_we,
    input  logic [CW-1:0]    wall_col,
    input  logic [RW-1:0]    wall_row,
    input  logic             wall_wdata,
    output logic [POS_W-1:0] pos_x,
    output logic [POS_W-1:0] pos_y,
    output logic [CW-1:0]    tile_col,
    output logic [RW-1:0]    tile_row,
    output logic [1:0]       facing,
    output logic             moving,
    output logic             bumped,
    output logic             done
);
    localparam int NT = COLS * ROWS;
    localparam int IW = $clog2(NT);
    localparam int OW = $clog2(TILE) + 1;

    typedef enum logic [1:0] {IDLE, CHECK, WALK} state_t;

    state_t           state_q, state_d;
    logic [1:0]       dir_q, dir_d, facing_q, facing_d;
    logic [CW-1:0]    col_q, col_d;
    logic [RW-1:0]    row_q, row_d;
    logic [OW-1:0]    off_q, off_d;
    logic [NT-1:0]    wall_q, wall_d;
    logic [POS_W-1:0] pos_x_q, pos_x_d, pos_y_q, pos_y_d;
    logic             ready_q, ready_d, moving_q, moving_d;
    logic             bumped_q, bumped_d, done_q, done_d;

    int               tgt_col, tgt_row, px, py;
    logic             at_edge, blocked;
    logic [IW-1:0]    tgt_idx, wr_idx;

    // Target tile of the latched direction; the bitmap is only consulted when the target is on the grid.
    always_comb begin
        tgt_col = int'(col_q);
        tgt_row = int'(row_q);
        at_edge = 1'b0;
        case (dir_q)
            2'd0: begin at_edge = (tgt_row == ROWS - 1); tgt_row = tgt_row + 1; end
            2'd1: begin at_edge = (tgt_row == 0);        tgt_row = tgt_row - 1; end
            2'd2: begin at_edge = (tgt_col == 0);        tgt_col = tgt_col - 1; end
            2'd3: begin at_edge = (tgt_col == COLS - 1); tgt_col = tgt_col + 1; end
        endcase
        tgt_idx = IW'(tgt_row * COLS + tgt_col);
        blocked = at_edge ? 1'b1 : wall_q[tgt_idx];
    end

    always_comb begin
        state_d  = state_q;
        dir_d    = dir_q;
        facing_d = facing_q;
        col_d    = col_q;
        row_d    = row_q;
        off_d    = off_q;
        wall_d   = wall_q;
        bumped_d = 1'b0;
        done_d   = 1'b0;

        wr_idx = IW'(int'(wall_row) * COLS + int'(wall_col));
        if (wall_we && int'(wall_col) < COLS && int'(wall_row) < ROWS) begin
            wall_d[wr_idx] = wall_wdata;
        end

        case (state_q)
            IDLE: begin
                if (warp_valid) begin
                    col_d = (int'(warp_col) > COLS - 1) ? CW'(COLS - 1) : warp_col;
                    row_d = (int'(warp_row) > ROWS - 1) ? RW'(ROWS - 1) : warp_row;
                    off_d = '0;
                end else if (move_valid) begin
                    dir_d    = move_dir;
                    facing_d = move_dir;
                    state_d  = CHECK;
                end
            end
            CHECK: begin
                off_d = '0;
                if (blocked) begin
                    bumped_d = 1'b1;
                    state_d  = IDLE;
                end else begin
                    state_d = WALK;
                end
            end
            WALK: begin
                if (frame_tick) begin
                    if (int'(off_q) + STEP_PX >= TILE) begin
                        col_d   = CW'(tgt_col);
                        row_d   = RW'(tgt_row);
                        off_d   = '0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        off_d = off_q + OW'(STEP_PX);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Position is computed from next-state values so pos leaves the flop aligned with tile/offset.
        px = ORIGIN_X + int'(col_d) * TILE;
        py = ORIGIN_Y + int'(row_d) * TILE;
        if (state_d == WALK) begin
            case (dir_d)
                2'd0: py = py + int'(off_d);
                2'd1: py = py - int'(off_d);
                2'd2: px = px - int'(off_d);
                2'd3: px = px + int'(off_d);
            endcase
        end
        pos_x_d  = POS_W'(px);
        pos_y_d  = POS_W'(py);
        ready_d  = (state_d == IDLE);
        moving_d = (state_d == WALK);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q  <= IDLE;
            dir_q    <= 2'd0;
            facing_q <= 2'd0;
            col_q    <= CW'(START_COL);
            row_q    <= RW'(START_ROW);
            off_q    <= '0;
            wall_q   <= '0;
            pos_x_q  <= POS_W'(ORIGIN_X + START_COL * TILE);
            pos_y_q  <= POS_W'(ORIGIN_Y + START_ROW * TILE);
            ready_q  <= 1'b1;
            moving_q <= 1'b0;
            bumped_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            dir_q    <= dir_d;
            facing_q <= facing_d;
            col_q    <= col_d;
            row_q    <= row_d;
            off_q    <= off_d;
            wall_q   <= wall_d;
            pos_x_q  <= pos_x_d;
            pos_y_q  <= pos_y_d;
            ready_q  <= ready_d;
            moving_q <= moving_d;
            bumped_q <= bumped_d;
            done_q   <= done_d;
        end
    end

    assign move_ready = ready_q;
    assign pos_x      = pos_x_q;
    assign pos_y      = pos_y_q;
    assign tile_col   = col_q;
    assign tile_row   = row_q;
    assign facing     = facing_q;
    assign moving     = moving_q;
    assign bumped     = bumped_q;
    assign done       = done_q;
endmodule

// File: tb/tb_tile_move_controller.sv
// tb/tb_tile_move_controller.sv - self-checking bench for tile_move_controller
// Grid-level reference model compared every cycle, plus directed literal expectations and random traffic.
module tb_tile_move_controller;
    localparam int COLS = 20, ROWS = 15, TILE = 32, STEP_PX = 4;
    localparam int OX = 0, OY = 0, SC = 5, SR = 5, POS_W = 10;
    localparam int CW = $clog2(COLS), RW = $clog2(ROWS);
    localparam int PMASK = (1 << POS_W) - 1;

    logic             Clk = 1'b0;
    logic             Reset_n = 1'b0;
    logic             frame_tick = 1'b0, move_valid = 1'b0, warp_valid = 1'b0;
    logic [1:0]       move_dir = 2'd0;
    logic [CW-1:0]    warp_col = '0, wall_col = '0;
    logic [RW-1:0]    warp_row = '0, wall_row = '0;
    logic             wall_we = 1'b0, wall_wdata = 1'b0;
    logic             move_ready, moving, bumped, done;
    logic [POS_W-1:0] pos_x, pos_y;
    logic [CW-1:0]    tile_col;
    logic [RW-1:0]    tile_row;
    logic [1:0]       facing;

    tile_move_controller #(
        .COLS(COLS), .ROWS(ROWS), .TILE(TILE), .STEP_PX(STEP_PX), .ORIGIN_X(OX), .ORIGIN_Y(OY),
        .START_COL(SC), .START_ROW(SR), .POS_W(POS_W)
    ) dut (
        .Clk(Clk), .Reset_n(Reset_n), .frame_tick(frame_tick), .move_valid(move_valid),
        .move_dir(move_dir), .move_ready(move_ready), .warp_valid(warp_valid),
        .warp_col(warp_col), .warp_row(warp_row), .wall_we(wall_we), .wall_col(wall_col),
        .wall_row(wall_row), .wall_wdata(wall_wdata), .pos_x(pos_x), .pos_y(pos_y),
        .tile_col(tile_col), .tile_row(tile_row), .facing(facing), .moving(moving),
        .bumped(bumped), .done(done)
    );

    always #5 Clk = ~Clk;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: sprite on a grid, a pending decision, and a count of walk ticks.
    int m_col, m_row, m_face, m_dir, m_steps;
    bit m_pending, m_walk, m_bump, m_done;
    bit m_wall[ROWS][COLS];

    always @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            m_col = SC; m_row = SR; m_face = 0; m_dir = 0; m_steps = 0;
            m_pending = 0; m_walk = 0; m_bump = 0; m_done = 0;
            foreach (m_wall[r, c]) m_wall[r][c] = 0;
        end else begin
            int dx, dy, nc, nr;
            m_bump = 0;
            m_done = 0;
            dx = (m_dir == 3) ? 1 : (m_dir == 2) ? -1 : 0;
            dy = (m_dir == 0) ? 1 : (m_dir == 1) ? -1 : 0;
            nc = m_col + dx;
            nr = m_row + dy;
            if (m_walk) begin
                if (frame_tick) begin
                    m_steps++;
                    if (m_steps * STEP_PX == TILE) begin
                        m_col = nc; m_row = nr; m_steps = 0; m_walk = 0; m_done = 1;
                    end
                end
            end else if (m_pending) begin
                m_pending = 0;
                if (nc < 0 || nc >= COLS || nr < 0 || nr >= ROWS || m_wall[nr][nc]) m_bump = 1;
                else begin m_walk = 1; m_steps = 0; end
            end else if (warp_valid) begin
                m_col = (int'(warp_col) > COLS - 1) ? COLS - 1 : int'(warp_col);
                m_row = (int'(warp_row) > ROWS - 1) ? ROWS - 1 : int'(warp_row);
            end else if (move_valid) begin
                m_dir = int'(move_dir); m_face = int'(move_dir); m_pending = 1;
            end
            if (wall_we && int'(wall_col) < COLS && int'(wall_row) < ROWS)
                m_wall[wall_row][wall_col] = wall_wdata;
        end
    end

    always @(negedge Clk) begin : compare
        int off, ex, ey;
        if (chk_en) begin
            off = m_walk ? m_steps * STEP_PX : 0;
            ex = OX + m_col * TILE + ((m_dir == 3) ? off : (m_dir == 2) ? -off : 0);
            ey = OY + m_row * TILE + ((m_dir == 0) ? off : (m_dir == 1) ? -off : 0);
            chk("pos_x", 32'(pos_x), ex & PMASK);
            chk("pos_y", 32'(pos_y), ey & PMASK);
            chk("tile_col", 32'(tile_col), m_col);
            chk("tile_row", 32'(tile_row), m_row);
            chk("facing", 32'(facing), m_face);
            chk("moving", 32'(moving), 32'(m_walk));
            chk("move_ready", 32'(move_ready), 32'(!m_walk && !m_pending));
            chk("bumped", 32'(bumped), 32'(m_bump));
            chk("done", 32'(done), 32'(m_done));
        end
    end

    // Inputs change 2 time units after a rising edge and are sampled on the next one.
    task automatic step(input bit ft, input bit mv, input logic [1:0] md, input bit wv,
                        input int wc, input int wr, input bit we, input int lc, input int lr,
                        input bit wd);
        frame_tick = ft; move_valid = mv; move_dir = md; warp_valid = wv;
        warp_col = CW'(wc); warp_row = RW'(wr);
        wall_we = we; wall_col = CW'(lc); wall_row = RW'(lr); wall_wdata = wd;
        @(posedge Clk);
        #2;
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic ticks(input int n, input bit mv);
        repeat (n) step(1, mv, 2'd3, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic mv_req(input logic [1:0] d);
        step(0, 1, d, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        idle(2);
        chk_en = 1'b1;
        chk("rst_pos_x_held", 32'(pos_x), 160);
        Reset_n = 1'b1;
        idle(1);
        chk("rst_pos_x", 32'(pos_x), 160);
        chk("rst_pos_y", 32'(pos_y), 160);
        chk("rst_tile_col", 32'(tile_col), 5);
        chk("rst_tile_row", 32'(tile_row), 5);
        chk("rst_facing", 32'(facing), 0);
        chk("rst_ready", 32'(move_ready), 1);

        mv_req(2'd3);
        chk("chk_ready_low", 32'(move_ready), 0);
        idle(1);
        chk("walk_moving", 32'(moving), 1);
        ticks(7, 0);
        chk("walk7_pos_x", 32'(pos_x), 188);
        chk("walk7_pos_y", 32'(pos_y), 160);
        ticks(1, 0);
        chk("walk_done", 32'(done), 1);
        chk("walk_tile_col", 32'(tile_col), 6);
        chk("walk_pos_x", 32'(pos_x), 192);
        chk("walk_ready", 32'(move_ready), 1);

        step(0, 0, 2'd0, 0, 0, 0, 1, 7, 5, 1);
        mv_req(2'd3);
        chk("wall_facing", 32'(facing), 3);
        idle(1);
        chk("wall_bumped", 32'(bumped), 1);
        chk("wall_ready", 32'(move_ready), 1);
        ticks(3, 0);
        chk("wall_pos_x", 32'(pos_x), 192);
        chk("wall_moving", 32'(moving), 0);

        step(0, 0, 2'd0, 1, 0, 0, 0, 0, 0, 0);
        chk("warp_pos_x", 32'(pos_x), 0);
        chk("warp_pos_y", 32'(pos_y), 0);
        mv_req(2'd1); idle(1);
        chk("up_bump", 32'(bumped), 1);
        mv_req(2'd2); idle(1);
        chk("left_bump", 32'(bumped), 1);
        mv_req(2'd0); idle(1);
        chk("down_no_bump", 32'(bumped), 0);
        ticks(8, 0);
        chk("down_tile_row", 32'(tile_row), 1);
        chk("down_pos_y", 32'(pos_y), 32);

        mv_req(2'd3);
        step(1, 1, 2'd3, 0, 0, 0, 0, 0, 0, 0);
        ticks(7, 1);
        chk("hold_pos_x", 32'(pos_x), 28);
        chk("hold_tile_col", 32'(tile_col), 0);
        ticks(1, 1);
        chk("hold_done", 32'(done), 1);
        chk("hold_tile_col2", 32'(tile_col), 1);
        idle(1);
        chk("hold_one_step", 32'(moving), 0);

        mv_req(2'd3); idle(1);
        ticks(3, 0);
        chk("pre_rst_pos_x", 32'(pos_x), 44);
        #1 Reset_n = 1'b0;
        #1;
        chk("async_pos_x", 32'(pos_x), 160);
        chk("async_pos_y", 32'(pos_y), 160);
        chk("async_moving", 32'(moving), 0);
        @(posedge Clk); #2;
        Reset_n = 1'b1;
        mv_req(2'd3); idle(1); ticks(8, 0);
        mv_req(2'd3); idle(1);
        chk("wall_cleared", 32'(moving), 1);
        ticks(8, 0);
        chk("past_wall_col", 32'(tile_col), 7);
        chk("past_wall_pos_x", 32'(pos_x), 224);

        step(0, 0, 2'd0, 1, 31, 15, 0, 0, 0, 0);
        chk("clamp_col", 32'(tile_col), 19);
        chk("clamp_row", 32'(tile_row), 14);
        chk("clamp_pos_x", 32'(pos_x), 608);
        mv_req(2'd3); idle(1);
        chk("right_edge_bump", 32'(bumped), 1);
        mv_req(2'd0); idle(1);
        chk("bottom_edge_bump", 32'(bumped), 1);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 399) == 0) Reset_n = 1'b0;
            else Reset_n = 1'b1;
            step($urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)),
                 $urandom_range(0, 15) == 0, $urandom_range(0, 31), $urandom_range(0, 15),
                 $urandom_range(0, 3) == 0, $urandom_range(0, 31), $urandom_range(0, 15),
                 $urandom_range(0, 3) == 0);
        end
        Reset_n = 1'b1;
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
